// File: rtl/bist_pkg.sv
// Shared definitions for the exhaustive-sweep BIST controller: FSM state
// encoding, default MISR constants and the single-step MISR function.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'h0000;

  // One Galois MISR step on a w-bit register (w <= 32), carried in 32-bit
  // containers so one function serves every signature width.
  function automatic logic [31:0] misr_step(input logic [31:0] m,
                                            input logic [31:0] poly,
                                            input logic [31:0] din,
                                            input int unsigned w);
    logic [31:0] mask;
    logic [31:0] fb;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    fb   = m[5'(w - 32'd1)] ? poly : 32'd0;
    return (((m << 1) ^ fb) ^ din) & mask;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register.
//   clk, rst_n : clock, asynchronous active-low reset (register clears to 0)
//   load       : load SEED (takes priority over en)
//   en         : absorb din for one MISR step
//   din        : parallel input, already zero-extended to SIG_W
//   m_next_c   : combinational value the register takes on an enabled step
module bist_misr
  import bist_pkg::*;
#(
  parameter int unsigned      SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] m_next_c
);

  logic [SIG_W-1:0] m;

  // Next-state value, exposed so the controller can capture the final signature
  // on the same edge the register absorbs the last vector.
  always_comb begin
    m_next_c = SIG_W'(misr_step(32'(m), 32'(POLY), 32'(din), SIG_W));
  end

  // Signature register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '0;
    end else if (load) begin
      m <= SEED;
    end else if (en) begin
      m <= m_next_c;
    end
  end

endmodule

// File: rtl/cut_bist_sweep.sv
// Exhaustive-sweep BIST controller for a combinational circuit under test.
// Drives every vector 0..2^N_IN-1 on cut_x, holds each for HOLD cycles,
// folds cut_f into a MISR on the last cycle of each hold window and reports
// the final signature plus a pass flag against golden.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a sweep (sampled only in IDLE)
//   golden     : expected signature, sampled at the final MISR update
//   cut_x      : registered vector to the CUT
//   cut_f      : CUT response (combinational from cut_x)
//   busy       : sweep in progress
//   done       : one-cycle pulse after the sweep
//   sig, pass  : final signature and sig==golden, held until next start
module cut_bist_sweep
  import bist_pkg::*;
#(
  parameter int unsigned      N_IN  = 11,
  parameter int unsigned      N_OUT = 16,
  parameter int unsigned      SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED),
  parameter int unsigned      HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SIG_W-1:0] golden,
  output logic [N_IN-1:0]  cut_x,
  input  logic [N_OUT-1:0] cut_f,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig,
  output logic             pass
);

  localparam int unsigned   HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  state_t           state;
  logic [HW-1:0]    hold_cnt;
  logic             load_c;
  logic             sample_c;
  logic [SIG_W-1:0] misr_in_c;
  logic [SIG_W-1:0] misr_next_c;

  // Sweep strobes: MISR seed load on accepted start, absorb on sample cycle
  always_comb begin
    load_c    = (state == IDLE) && start;
    sample_c  = (state == RUN) && (hold_cnt == HOLD_LAST);
    misr_in_c = SIG_W'(cut_f);
  end

  bist_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .en       (sample_c),
    .din      (misr_in_c),
    .m_next_c (misr_next_c)
  );

  // Controller FSM with vector and hold counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cut_x    <= '0;
      hold_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sig      <= '0;
      pass     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cut_x    <= '0;
            hold_cnt <= '0;
            pass     <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            // The all-ones vector terminates the sweep, so cut_x never wraps.
            if (&cut_x) begin
              sig   <= misr_next_c;
              pass  <= (misr_next_c == golden);
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cut_x <= cut_x + N_IN'(1);
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
